// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: sequencer states, primary opcodes and ALUOp
// encodings used by the decoder, the stall controller and the bench.
package mips_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clr wins over inc.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // count register with saturation at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= {W{1'b0}};
    end else if (clr) begin
      count <= {W{1'b0}};
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use interlock, MEM-stage
// branch flush, variable-latency data-memory handshake with watchdog, perf counters.
import mips_pkg::*;

module pipeline_stall_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             mem_access,
  input  logic             mem_branch_taken,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  // Counter only needs to reach MEM_TIMEOUT-1.
  localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit WD_EN = (MEM_TIMEOUT > 0);
  localparam logic [TO_W-1:0] TO_LAST = WD_EN ? TO_W'(MEM_TIMEOUT - 1) : {TO_W{1'b0}};

  state_t          state_r, state_nxt_s;
  logic [TO_W-1:0] to_cnt_r;
  logic            timeout_hit_s, mem_hold_s, load_use_s, wd_fire_s;
  logic            stall_inc_s, flush_inc_s;

  // hazard detection, hold condition and next state
  always_comb begin
    load_use_s    = ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    timeout_hit_s = 1'b0;
    mem_hold_s    = 1'b0;
    wd_fire_s     = 1'b0;
    state_nxt_s   = state_r;
    case (state_r)
      RUN: begin
        mem_hold_s = mem_access && !dmem_ready;
        if (mem_access && !dmem_ready) begin
          state_nxt_s = MEM_WAIT;
        end else begin
          state_nxt_s = RUN;
        end
      end
      MEM_WAIT: begin
        timeout_hit_s = WD_EN && (to_cnt_r == TO_LAST);
        mem_hold_s    = !dmem_ready && !timeout_hit_s;
        wd_fire_s     = !dmem_ready && timeout_hit_s;
        if (dmem_ready || timeout_hit_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = MEM_WAIT;
        end
      end
      default: begin
        state_nxt_s = RUN;
      end
    endcase
  end

  // Mealy enables/flushes in priority order: memory hold, branch, load-use
  always_comb begin
    dmem_req    = (state_r == MEM_WAIT) || mem_access;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    stall_inc_s = 1'b0;
    flush_inc_s = 1'b0;
    if (mem_hold_s) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
      stall_inc_s = 1'b1;
    end else if (mem_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      flush_inc_s = 1'b1;
    end else if (load_use_s) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_flush  = 1'b1;
      stall_inc_s = 1'b1;
    end else begin
      stall_inc_s = 1'b0;
      flush_inc_s = 1'b0;
    end
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // watchdog: cleared while running, counts each unanswered wait cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else if (state_r == RUN) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else if (!dmem_ready && !timeout_hit_s) begin
      to_cnt_r <= to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end

  // sticky timeout flag, only reset clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_err <= 1'b0;
    end else if (wd_fire_s) begin
      mem_err <= 1'b1;
    end else begin
      mem_err <= mem_err;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc_s),
    .clr   (1'b0),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc_s),
    .clr   (1'b0),
    .count (flush_count)
  );

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Central stall/flush sequencer for the five-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Generates the PC and pipeline-register enables and flushes for three cases: load-use hazards, taken branches resolved in MEM, and variable-latency data-memory accesses.
- Owns the data-memory request handshake, including a timeout watchdog, and saturating performance counters.
- Sits beside the main opcode decoder; consumes its MemRead/MemWrite/Branch outputs after they have been staged through the pipeline registers.

Parameters:
- MEM_TIMEOUT, 64, max cycles in MEM_WAIT before forced release; 0 disables the watchdog.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt (R-type, sw, beq).
- ex_mem_read  in  1  MemRead of the instruction in EX.
- ex_rt  in  5  destination rt of the instruction in EX.
- mem_access  in  1  MemRead|MemWrite of the instruction in MEM.
- mem_branch_taken  in  1  Branch & zero of the instruction in MEM.
- dmem_ready  in  1  data memory completes the access this cycle.
- dmem_req  out  1  data-memory request.
- pc_en  out  1  PC load enable.
- ifid_en, idex_en, exmem_en  out  1 each  pipeline-register enables.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load a bubble (all control bits 0).
- mem_err  out  1  sticky watchdog-timeout flag.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0.
- flush_count  out  CNT_W  saturating count of taken-branch flushes.

Behaviour:
- FSM states: RUN, MEM_WAIT. Outputs are Mealy (state + current inputs). Counters and mem_err are registered.
- Reset (async, any time including mid-wait):
  - state=RUN, timeout counter=0, mem_err=0, stall_cycles=0, flush_count=0.
  - With all inputs 0: all enables=1, all flushes=0, dmem_req=0.
- mem_hold = (RUN & mem_access & !dmem_ready) | (MEM_WAIT & !dmem_ready & !timeout_hit).
- dmem_req = (RUN & mem_access) | MEM_WAIT.
- Priority, highest first:
  1. mem_hold: pc_en=ifid_en=idex_en=exmem_en=0, memwb_flush=1, all other flushes 0. A pending branch or load-use condition is ignored this cycle.
  2. mem_branch_taken: all enables=1; ifid_flush=idex_flush=exmem_flush=1; flush_count++.
  3. load_use: pc_en=ifid_en=0, idex_flush=1, exmem_en=1.
  4. Otherwise: all enables=1, no flushes.
- load_use = ex_mem_read & (ex_rt!=0) & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
- Zero-wait access (RUN, mem_access & dmem_ready): no stall, state stays RUN.
- Transitions:
  - RUN -> MEM_WAIT on mem_access & !dmem_ready; timeout counter cleared.
  - MEM_WAIT -> RUN on dmem_ready. That cycle is not held; rules 2-4 apply, so a taken branch waiting in MEM flushes in its release cycle.
- Watchdog (MEM_TIMEOUT>0):
  - The timeout counter increments each MEM_WAIT cycle without ready.
  - timeout_hit = counter==MEM_TIMEOUT-1. When hit, the cycle is released as if ready, mem_err sets (cleared only by rst), and state -> RUN.
- Counters: saturate at all-ones. stall_cycles increments in every cycle with pc_en=0 (cases 1 and 3).

Decomposition:
- Shared package mips_pkg:
  - state enum {RUN, MEM_WAIT}.
  - Opcode constants (R-type 000000, lw 100011, sw 101011, beq 000100, ori 001101), reused by the decoder and the testbench.
  - ALUOp encodings.
- One natural sub-module: sat_counter (parameter W; inputs inc, clr; async rst), instantiated twice.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=5, id_rs=5 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1, stall_cycles=1. ex_rt=0 with id_rs=0 -> no stall.
- Branch flush: mem_branch_taken=1 with load_use also true -> ifid/idex/exmem_flush=1, pc_en=1, flush_count=1, stall_cycles unchanged.
- Memory wait: mem_access=1, dmem_ready=0 for 3 cycles then 1 -> dmem_req=1 for 4 cycles, enables=0 and memwb_flush=1 for 3 cycles, state back to RUN, stall_cycles=3.
- Branch during wait: mem_branch_taken=1 held through a 2-cycle wait -> no flush while held; flush asserted exactly in the ready cycle.
- Timeout: MEM_TIMEOUT=4, dmem_ready never asserted -> release on 4th MEM_WAIT cycle, mem_err=1 and remains set; rst mid-wait -> RUN, mem_err=0, counters 0, dmem_req=0.
- Saturation: CNT_W=4, 20 load-use stalls -> stall_cycles holds 15.
